hssl_rx_frame_decoder: RTL and testbench

- Receive-side user logic for the HSSL link. Runs in the GT rx_usrclk2 domain.
- Consumes the 32-bit 8b/10b-decoded word stream and byte flags from the GT receiver.
- Tracks link lock, extracts length-prefixed frames into a commit-on-complete FIFO, and presents whole, error-free frames on a valid/ready stream to the downstream packet logic.

---
 rtl/hssl_rx_frame_decoder_if.sv | 25 ++
 rtl/hssl_rx_frame_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_hssl_rx_frame_decoder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hssl_rx_frame_decoder_if.sv
// hssl_rx_frame_decoder_if
//   Bundles the GT receive word stream (decoded data plus per-byte flags) and
//   the downstream valid/ready payload stream of the HSSL RX frame decoder.
//   master : drives rx_* and rdy_in, observes dat_out/vld_out/last_out
//   slave  : the decoder side
interface hssl_rx_frame_decoder_if;
  logic [31:0] rx_data_in;
  logic [3:0]  rx_charisk_in;
  logic [3:0]  rx_disperr_in;
  logic [3:0]  rx_encerr_in;
  logic [31:0] dat_out;
  logic        vld_out;
  logic        last_out;
  logic        rdy_in;

  modport master (
    output rx_data_in, rx_charisk_in, rx_disperr_in, rx_encerr_in, rdy_in,
    input  dat_out, vld_out, last_out
  );

  modport slave (
    input  rx_data_in, rx_charisk_in, rx_disperr_in, rx_encerr_in, rdy_in,
    output dat_out, vld_out, last_out
  );
endinterface

// File: rtl/hssl_rx_frame_decoder.sv
// hssl_rx_frame_decoder
//   HSSL receive user logic in the rx_usrclk2 domain. Registers the decoded GT
//   word stream, tracks link lock on K28.5 idles, extracts length-prefixed
//   frames (SOF = K28.1, length in byte 1) into a commit-on-complete FIFO and
//   presents only whole, error-free frames on a valid/ready stream.
// Ports:
//   clk            rx_usrclk2
//   reset_n        asynchronous active-low reset
//   bus            slave side: rx_data/charisk/disperr/encerr in,
//                  dat_out/vld_out/last_out out, rdy_in in
//   lock_out       link locked
//   rx_frames_out  delivered frame count   (HSSL_RX_STATS_EN, else 0)
//   rx_dropped_out dropped frame count     (HSSL_RX_STATS_EN, else 0)
//   rx_errors_out  code error word count   (HSSL_RX_STATS_EN, else 0)
// Optional build macro: HSSL_RX_STATS_EN enables the three counters.
module hssl_rx_frame_decoder #(
  parameter int SYNC_CNT = 16,
  parameter int ERR_THR  = 4,
  parameter int ERR_WIN  = 256,
  parameter int MAX_LEN  = 16,
  parameter int FIFO_AW  = 6
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hssl_rx_frame_decoder_if.slave bus,
  output logic                   lock_out,
  output logic [15:0]            rx_frames_out,
  output logic [15:0]            rx_dropped_out,
  output logic [15:0]            rx_errors_out
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int SCW   = $clog2(SYNC_CNT + 1);
  localparam int WW    = $clog2(ERR_WIN + 1);
  localparam int ECW   = $clog2(ERR_THR + 1);

  typedef enum logic {LOS, LOCKED}  lock_st_t;
  typedef enum logic {F_IDLE, F_PAY} frm_st_t;

  // stage 1: input register
  logic [31:0] r_data;
  logic [3:0]  r_isk, r_derr, r_eerr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0; r_isk <= '0; r_derr <= '0; r_eerr <= '0;
    end else begin
      r_data <= bus.rx_data_in;
      r_isk  <= bus.rx_charisk_in;
      r_derr <= bus.rx_disperr_in;
      r_eerr <= bus.rx_encerr_in;
    end
  end

  // stage 2: classification. A code error overrides every other class.
  logic       w_err, w_bad, w_idle, w_sof, w_data;
  logic [7:0] w_len;
  assign w_err  = (|r_derr) | (|r_eerr);
  assign w_bad  = |r_isk[3:1];
  assign w_idle = !w_err && !w_bad && r_isk[0] && (r_data[7:0] == 8'hBC);
  assign w_sof  = !w_err && !w_bad && r_isk[0] && (r_data[7:0] == 8'h3C);
  assign w_data = !w_err && (r_isk == 4'b0000);
  assign w_len  = r_data[15:8];

  // lock FSM
  lock_st_t       r_lock_st, w_lock_nxt;
  logic [SCW-1:0] r_sync_cnt, w_sync_nxt;
  logic [WW-1:0]  r_win_cnt, w_win_nxt;
  logic [ECW-1:0] r_err_cnt, w_ecnt_nxt, w_ecnt_base;
  logic           w_locked, w_win_wrap;

  assign w_locked   = (r_lock_st == LOCKED);
  assign w_win_wrap = (r_win_cnt == WW'(ERR_WIN - 1));

  always_comb begin
    w_lock_nxt  = r_lock_st;
    w_sync_nxt  = r_sync_cnt;
    w_win_nxt   = r_win_cnt;
    w_ecnt_base = r_err_cnt;
    w_ecnt_nxt  = r_err_cnt;
    case (r_lock_st)
      LOS: begin
        w_win_nxt  = '0;
        w_ecnt_nxt = '0;
        if (!w_idle) w_sync_nxt = '0;
        else if (r_sync_cnt == SCW'(SYNC_CNT - 1)) begin
          w_lock_nxt = LOCKED;
          w_sync_nxt = '0;
        end else w_sync_nxt = r_sync_cnt + 1'b1;
      end
      LOCKED: begin
        // the wrapping word opens a fresh window and still counts in it
        w_win_nxt   = w_win_wrap ? '0 : r_win_cnt + 1'b1;
        w_ecnt_base = w_win_wrap ? '0 : r_err_cnt;
        w_ecnt_nxt  = w_err ? w_ecnt_base + 1'b1 : w_ecnt_base;
        if (w_ecnt_nxt == ECW'(ERR_THR)) begin
          w_lock_nxt = LOS;
          w_win_nxt  = '0;
          w_ecnt_nxt = '0;
        end
      end
      default: w_lock_nxt = LOS;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_st <= LOS; r_sync_cnt <= '0; r_win_cnt <= '0; r_err_cnt <= '0;
    end else begin
      r_lock_st <= w_lock_nxt; r_sync_cnt <= w_sync_nxt;
      r_win_cnt <= w_win_nxt;  r_err_cnt  <= w_ecnt_nxt;
    end
  end

  assign lock_out = w_locked;

  // frame FSM; r_wps is the speculative write pointer, r_wpc the committed one
  frm_st_t       r_frm_st, w_frm_nxt;
  logic [7:0]    r_rem, w_rem_nxt;
  logic [PW-1:0] r_wps, r_wpc, r_rp, w_wps_nxt, w_wpc_nxt, w_free;
  logic          w_wr_en, w_wr_last, w_frame_done, w_drop;

  assign w_free = PW'(DEPTH) - (r_wps - r_rp);

  always_comb begin
    w_frm_nxt    = r_frm_st;
    w_rem_nxt    = r_rem;
    w_wps_nxt    = r_wps;
    w_wpc_nxt    = r_wpc;
    w_wr_en      = 1'b0;
    w_wr_last    = 1'b0;
    w_frame_done = 1'b0;
    w_drop       = 1'b0;
    case (r_frm_st)
      F_IDLE: if (w_locked && w_sof) begin
        if (w_len == 8'd0 || 32'(w_len) > MAX_LEN) w_drop = 1'b1;
        // reserve the whole frame up front so a write is never refused later
        else if (32'(w_free) < 32'(w_len))         w_drop = 1'b1;
        else begin
          w_frm_nxt = F_PAY;
          w_rem_nxt = w_len;
        end
      end
      F_PAY: if (w_locked && w_data) begin
        w_wr_en   = 1'b1;
        w_wr_last = (r_rem == 8'd1);
        w_wps_nxt = r_wps + 1'b1;
        w_rem_nxt = r_rem - 1'b1;
        if (w_wr_last) begin
          w_wpc_nxt    = r_wps + 1'b1;
          w_frame_done = 1'b1;
          w_frm_nxt    = F_IDLE;
        end
      end else begin
        // abort: rewind, and an aborting SOF is not re-parsed
        w_wps_nxt = r_wpc;
        w_drop    = 1'b1;
        w_frm_nxt = F_IDLE;
      end
      default: w_frm_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frm_st <= F_IDLE; r_rem <= '0; r_wps <= '0; r_wpc <= '0;
    end else begin
      r_frm_st <= w_frm_nxt; r_rem <= w_rem_nxt;
      r_wps    <= w_wps_nxt; r_wpc <= w_wpc_nxt;
    end
  end

  // FIFO storage {last, data}
  logic [32:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wps[FIFO_AW-1:0]] <= {w_wr_last, r_data};
  end

  // first-word-fall-through output register; only committed words are visible
  logic [31:0] r_dat;
  logic        r_vld, r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rp <= '0; r_vld <= 1'b0; r_dat <= '0; r_last <= 1'b0;
    end else if (!r_vld || bus.rdy_in) begin
      if (r_rp != r_wpc) begin
        {r_last, r_dat} <= r_mem[r_rp[FIFO_AW-1:0]];
        r_vld <= 1'b1;
        r_rp  <= r_rp + 1'b1;
      end else r_vld <= 1'b0;
    end
  end

  assign bus.dat_out  = r_dat;
  assign bus.vld_out  = r_vld;
  assign bus.last_out = r_last;

`ifdef HSSL_RX_STATS_EN
  logic [15:0] r_frames, r_drops, r_errs;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frames <= '0; r_drops <= '0; r_errs <= '0;
    end else begin
      r_frames <= r_frames + {15'd0, w_frame_done};
      r_drops  <= r_drops  + {15'd0, w_drop};
      r_errs   <= r_errs   + {15'd0, w_err};
    end
  end
  assign rx_frames_out  = r_frames;
  assign rx_dropped_out = r_drops;
  assign rx_errors_out  = r_errs;
`else
  logic w_unused_stats;
  assign w_unused_stats = ^{w_frame_done, w_drop, w_err};
  assign rx_frames_out  = '0;
  assign rx_dropped_out = '0;
  assign rx_errors_out  = '0;
`endif
endmodule

// File: tb/tb_hssl_rx_frame_decoder.sv
module tb_hssl_rx_frame_decoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        lock_out;
  logic [15:0] rx_frames_out, rx_dropped_out, rx_errors_out;

  hssl_rx_frame_decoder_if bus();

  hssl_rx_frame_decoder dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .lock_out(lock_out),
    .rx_frames_out(rx_frames_out), .rx_dropped_out(rx_dropped_out),
    .rx_errors_out(rx_errors_out)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, lock_cyc = 0;
  int n_out = 0, n_last = 0;
  int ef = 0, ed = 0, ee = 0;
  logic [32:0] sb[$];

  typedef struct { int len; bit ok; } fvec_t;
  fvec_t tbl [6];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ex(input int v);
`ifdef HSSL_RX_STATS_EN
    return 64'(v & 16'hffff);
`else
    return 64'(v * 0);
`endif
  endfunction

  // stream monitor: scoreboard compare and hold-while-stalled check
  logic        p_vld = 1'b0, p_rdy = 1'b0;
  logic [32:0] p_word = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (p_vld && !p_rdy) begin
        chk("hold_vld", 64'(bus.vld_out), 64'd1);
        chk("hold_dat", 64'({bus.last_out, bus.dat_out}), 64'(p_word));
      end
      if (bus.vld_out && bus.rdy_in) begin
        n_out++;
        if (bus.last_out) n_last++;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_word act=%0h exp=none", {bus.last_out, bus.dat_out});
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("stream_word", 64'({bus.last_out, bus.dat_out}), 64'(e));
        end
      end
      p_vld  = bus.vld_out;
      p_rdy  = bus.rdy_in;
      p_word = {bus.last_out, bus.dat_out};
    end
  end

  task automatic put(input logic [31:0] d, input logic [3:0] k,
                     input logic [3:0] de, input logic [3:0] ee_i);
    bus.rx_data_in    = d;
    bus.rx_charisk_in = k;
    bus.rx_disperr_in = de;
    bus.rx_encerr_in  = ee_i;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) put(32'h0000_00BC, 4'b0001, 4'd0, 4'd0);
  endtask

  task automatic sof(input int len);
    put({16'h0, 8'(len), 8'h3C}, 4'b0001, 4'd0, 4'd0);
  endtask

  task automatic send_frame(input int len, input bit ok);
    sof(len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] d;
      d = $urandom;
      put(d, 4'b0000, 4'd0, 4'd0);
      if (ok) sb.push_back({(i == len - 1), d});
    end
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((sb.size() != 0 || bus.vld_out) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= max) begin
      total++; bad++;
      $display("FAIL drain_timeout act=%0d_left exp=0", sb.size());
    end
  endtask

  initial begin
    tbl[0] = '{1, 1'b1};
    tbl[1] = '{0, 1'b0};
    tbl[2] = '{17, 1'b0};
    tbl[3] = '{16, 1'b1};
    tbl[4] = '{5, 1'b1};
    tbl[5] = '{2, 1'b1};

    bus.rx_data_in = 32'hBC; bus.rx_charisk_in = 4'b0001;
    bus.rx_disperr_in = '0;  bus.rx_encerr_in = '0;
    bus.rdy_in = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_lock", 64'(lock_out), 64'd0);
    chk("rst_vld", 64'(bus.vld_out), 64'd0);
    chk("rst_last", 64'(bus.last_out), 64'd0);
    chk("rst_dat", 64'(bus.dat_out), 64'd0);
    chk("rst_frames", 64'(rx_frames_out), 64'd0);
    chk("rst_drop", 64'(rx_dropped_out), 64'd0);
    chk("rst_errs", 64'(rx_errors_out), 64'd0);
    reset_n = 1'b1;

    // lock acquisition: a DATA word breaks the idle run
    idle(15);
    put(32'h1111_2222, 4'b0000, 4'd0, 4'd0);
    idle(15);
    chk("nolock_broken_run", 64'(lock_out), 64'd0);
    idle(1);  // 16th consecutive idle captured, not yet classified
    chk("nolock_16_pending", 64'(lock_out), 64'd0);
    idle(1);
    chk("lock_after_16", 64'(lock_out), 64'd1);
    lock_cyc = cyc;

    // L=3 frame with exact first-valid latency
    sof(3);
    for (int i = 0; i < 3; i++) begin
      logic [31:0] d;
      d = 32'hA0A0_0000 + 32'(i);
      put(d, 4'b0000, 4'd0, 4'd0);
      sb.push_back({(i == 2), d});
    end
    idle(1);
    chk("lat_vld_early", 64'(bus.vld_out), 64'd0);
    idle(1);
    chk("lat_vld_t3", 64'(bus.vld_out), 64'd1);
    idle(6);
    ef++;
    wait_drain(100);
    chk("frames_l3", 64'(rx_frames_out), ex(ef));

    // encerr mid-frame aborts; next clean L=1 frame stands alone
    sof(4);
    put(32'hDEAD_0001, 4'b0000, 4'd0, 4'd0);
    put(32'hDEAD_0002, 4'b0000, 4'd0, 4'd0);
    put(32'hDEAD_0003, 4'b0000, 4'd0, 4'b0010);
    send_frame(1, 1'b1);
    ed++; ee++; ef++;
    idle(6);
    wait_drain(100);
    chk("abort_drop", 64'(rx_dropped_out), ex(ed));
    chk("abort_errs", 64'(rx_errors_out), ex(ee));
    chk("abort_frames", 64'(rx_frames_out), ex(ef));

    // table of length cases including the L=0 / L>MAX_LEN boundaries
    for (int t = 0; t < 6; t++) begin
      send_frame(tbl[t].len, tbl[t].ok);
      if (tbl[t].ok) ef++; else ed++;
      idle(4);
      wait_drain(200);
      chk($sformatf("tbl%0d_frames", t), 64'(rx_frames_out), ex(ef));
      chk($sformatf("tbl%0d_drop", t), 64'(rx_dropped_out), ex(ed));
      chk($sformatf("tbl%0d_empty", t), 64'(bus.vld_out), 64'd0);
    end

    // backpressure: four 16-word frames fill the FIFO, the fifth is dropped
    begin
      int o0, l0;
      o0 = n_out; l0 = n_last;
      bus.rdy_in = 1'b0;
      for (int f = 0; f < 5; f++) send_frame(16, f < 4);
      ef += 4; ed++;
      idle(5);
      chk("bp_drop", 64'(rx_dropped_out), ex(ed));
      chk("bp_vld_held", 64'(bus.vld_out), 64'd1);
      chk("bp_no_out", 64'(n_out - o0), 64'd0);
      bus.rdy_in = 1'b1;
      wait_drain(300);
      chk("bp_words", 64'(n_out - o0), 64'd64);
      chk("bp_lasts", 64'(n_last - l0), 64'd4);
      chk("bp_frames", 64'(rx_frames_out), ex(ef));
    end

    // four ERR words in one window while in F_PAY; keep them clear of a
    // window boundary (first window word is classified one edge after lock)
    while (((cyc + 4 - lock_cyc) % 256) > 200) idle(1);
    sof(8);
    put(32'h5555_0001, 4'b0000, 4'd0, 4'd0);
    put(32'h5555_0002, 4'b0000, 4'd0, 4'd0);
    repeat (4) put(32'h0, 4'b0000, 4'b0001, 4'd0);
    ed++; ee += 4;
    idle(2);
    chk("err_lock_lost", 64'(lock_out), 64'd0);
    idle(16);
    chk("relock", 64'(lock_out), 64'd1);
    idle(4);
    wait_drain(100);
    chk("err_drop", 64'(rx_dropped_out), ex(ed));
    chk("err_errs", 64'(rx_errors_out), ex(ee));
    chk("final_frames", 64'(rx_frames_out), ex(ef));
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
